// File: rtl/rf_wb_queue_if.sv
// Bundle of every signal between the register-file write-back queue and its
// surroundings: producers A/B, the register-file write port, the forwarding
// lookup and the occupancy count.
//
// Handshake rule for both producers: a request is transferred on a rising clk
// edge where valid and ready are both high. The producer keeps valid, addr and
// data stable until that edge. ready may depend on valid combinationally
// (b_ready is low whenever a_valid is high).
interface rf_wb_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  // producer A (ALU)
  logic                    a_valid;
  logic                    a_ready;
  logic [AW-1:0]           a_addr;
  logic [DW-1:0]           a_data;
  // producer B (load unit)
  logic                    b_valid;
  logic                    b_ready;
  logic [AW-1:0]           b_addr;
  logic [DW-1:0]           b_data;
  // register-file write port
  logic                    wr_stall;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [DW-1:0]           wr_data;
  // forwarding lookup
  logic [AW-1:0]           lk_addrA;
  logic [AW-1:0]           lk_addrB;
  logic                    fwd_hitA;
  logic [DW-1:0]           fwd_dataA;
  logic                    fwd_hitB;
  logic [DW-1:0]           fwd_dataB;
  // occupancy
  logic [$clog2(DEPTH):0]  count;

  // Producer / environment side
  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output wr_stall, lk_addrA, lk_addrB,
    input  a_ready, b_ready,
    input  wr_en, wr_addr, wr_data,
    input  fwd_hitA, fwd_dataA, fwd_hitB, fwd_dataB,
    input  count
  );

  // Queue side
  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  wr_stall, lk_addrA, lk_addrB,
    output a_ready, b_ready,
    output wr_en, wr_addr, wr_data,
    output fwd_hitA, fwd_dataA, fwd_hitB, fwd_dataB,
    output count
  );
endinterface

// File: rtl/rf_wb_queue.sv
// Write-back queue in front of the register file's single write port.
// Two producers (A has fixed priority) push into a DEPTH-entry circular FIFO;
// the head drains into the register file whenever the port is not stalled.
// Writes to x0 complete the handshake but are discarded. A forwarding lookup
// returns the youngest pending value for two read addresses.
module rf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic         clk,
  input  logic         nrst,
  rf_wb_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // storage and bookkeeping
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // handshake / control
  logic          pop;
  logic          space;
  logic          a_fire;
  logic          b_fire;
  logic          push;
  logic [AW-1:0] push_addr;
  logic [DW-1:0] push_data;

  // forwarding results
  logic          hit_a, hit_b;
  logic [DW-1:0] fdata_a, fdata_b;

  // Control: pop when non-empty and port free; a full queue still accepts
  // when the head leaves in the same cycle.
  always_comb begin
    pop       = (count_q != '0) & ~bus.wr_stall;
    space     = (count_q < CW'(DEPTH)) | pop;
    a_fire    = bus.a_valid & space;
    b_fire    = bus.b_valid & space & ~bus.a_valid;
    push_addr = bus.a_valid ? bus.a_addr : bus.b_addr;
    push_data = bus.a_valid ? bus.a_data : bus.b_data;
    push      = (a_fire | b_fire) & (push_addr != '0);
  end

  // Next-state for pointers, count and valid bits. Pop clears before push
  // sets, so a full-queue pop+push reusing the head slot leaves it valid.
  always_comb begin
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push};
    count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    valid_d  = valid_q;
    if (pop)  valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;
  end

  // Bookkeeping registers; reset drops every queued entry.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= push_addr;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  // Forwarding: walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    hit_a   = 1'b0;
    hit_b   = 1'b0;
    fdata_a = '0;
    fdata_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (valid_q[idx] && (bus.lk_addrA != '0) && (addr_q[idx] == bus.lk_addrA)) begin
        hit_a   = 1'b1;
        fdata_a = data_q[idx];
      end
      if (valid_q[idx] && (bus.lk_addrB != '0) && (addr_q[idx] == bus.lk_addrB)) begin
        hit_b   = 1'b1;
        fdata_b = data_q[idx];
      end
    end
  end

  assign bus.a_ready   = space;
  assign bus.b_ready   = space & ~bus.a_valid;
  assign bus.wr_en     = pop;
  assign bus.wr_addr   = addr_q[rd_ptr_q];
  assign bus.wr_data   = data_q[rd_ptr_q];
  assign bus.fwd_hitA  = hit_a;
  assign bus.fwd_dataA = fdata_a;
  assign bus.fwd_hitB  = hit_b;
  assign bus.fwd_dataB = fdata_b;
  assign bus.count     = count_q;

endmodule
